// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_alu
// Description : 32-bit datapath ALU driven by the 4-bit ALUOperation code.
//               AND/OR/NOR/ADD/SUB finish in one cycle. SLL/SRL use an
//               iterative shifter that moves one bit per cycle. A
//               start/busy/done handshake lets the multicycle controller
//               stall until ALUResult and Zero are valid.
// Ports       : clk          - rising-edge clock
//               reset        - asynchronous active-high reset
//               start        - request pulse, sampled only in IDLE
//               ALUOperation - operation code
//               A, B         - operands (B is the shifted operand)
//               shamt        - shift amount
//               busy         - high whenever the FSM is not IDLE
//               done         - one-cycle pulse, result valid
//               ALUResult    - registered result, held until next completion
//               Zero         - registered, 1 iff ALUResult == 0
//               InvalidOp    - registered, 1 iff last completed op unsupported
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             ALUOperation,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  ALUResult,
    output logic                   Zero,
    output logic                   InvalidOp
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_NOR = 4'b0010;
    localparam logic [3:0] c_OP_ADD = 4'b0011;
    localparam logic [3:0] c_OP_SUB = 4'b0100;
    localparam logic [3:0] c_OP_SLL = 4'b1111;
    localparam logic [3:0] c_OP_SRL = 4'b1110;

    localparam logic [SHAMT_WIDTH-1:0] c_CNT_ONE  = SHAMT_WIDTH'(1);
    localparam logic [SHAMT_WIDTH-1:0] c_CNT_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [DATA_WIDTH-1:0]   r_shreg;
    logic [SHAMT_WIDTH-1:0]  r_cnt;
    logic                    r_dir_left;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_zero;
    logic                    r_invalid;

    logic [DATA_WIDTH-1:0]   w_alu_result;
    logic                    w_op_valid;
    logic                    w_is_shift;
    logic                    w_shift_left;
    logic                    w_start_shift;
    logic [DATA_WIDTH-1:0]   w_shift_step;

    // Single-cycle result. Shift codes return B here, which is exactly the
    // answer for shamt == 0; nonzero shamt goes through the iterative path.
    always_comb begin
        w_alu_result = '0;
        w_op_valid   = 1'b1;
        w_is_shift   = 1'b0;
        w_shift_left = 1'b0;
        case (ALUOperation)
            c_OP_AND: w_alu_result = A & B;
            c_OP_OR:  w_alu_result = A | B;
            c_OP_NOR: w_alu_result = ~(A | B);
            c_OP_ADD: w_alu_result = A + B;
            c_OP_SUB: w_alu_result = A - B;
            c_OP_SLL: begin
                w_alu_result = B;
                w_is_shift   = 1'b1;
                w_shift_left = 1'b1;
            end
            c_OP_SRL: begin
                w_alu_result = B;
                w_is_shift   = 1'b1;
            end
            default:  w_op_valid = 1'b0;
        endcase
    end

    assign w_start_shift = w_is_shift && (shamt != c_CNT_ZERO);
    assign w_shift_step  = r_dir_left ? (r_shreg << 1) : (r_shreg >> 1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_start_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Datapath registers. Outputs only move at completion so the controller
    // can keep reading Zero after done has dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_dir_left <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_invalid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_start_shift) begin
                            r_shreg    <= B;
                            r_cnt      <= shamt;
                            r_dir_left <= w_shift_left;
                        end else begin
                            r_result  <= w_alu_result;
                            r_zero    <= (w_alu_result == '0);
                            r_invalid <= ~w_op_valid;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_shreg <= w_shift_step;
                    r_cnt   <= r_cnt - c_CNT_ONE;
                    // Last step: publish the shifted value directly so the
                    // result is visible in the same cycle done rises.
                    if (r_cnt == c_CNT_ONE) begin
                        r_result  <= w_shift_step;
                        r_zero    <= (w_shift_step == '0);
                        r_invalid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign ALUResult = r_result;
    assign Zero      = r_zero;
    assign InvalidOp = r_invalid;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_alu
// Description : Directed self-checking bench for multicycle_alu. Each step
//               issues one operation and compares latency, handshake and
//               registered outputs against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        InvalidOp;

    int n_pass;
    int n_total;

    multicycle_alu #(
        .DATA_WIDTH  (32),
        .SHAMT_WIDTH (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (ALUOperation),
        .A            (A),
        .B            (B),
        .shamt        (shamt),
        .busy         (busy),
        .done         (done),
        .ALUResult    (ALUResult),
        .Zero         (Zero),
        .InvalidOp    (InvalidOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at the falling edge; returns #1 after the start edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        @(negedge clk);
        ALUOperation = op;
        A            = a;
        B            = b;
        shamt        = sh;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        // Scramble inputs: the design must have latched them.
        A            = 32'h1234_5678;
        B            = 32'h0BAD_F00D;
        shamt        = 5'd7;
        ALUOperation = 4'b0011;
    endtask

    // Wait for done; lat counts cycles from the start edge (1 = next cycle).
    task automatic wait_done(input int lat_init, output int lat);
        lat = lat_init;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_inv,
                          input int exp_lat);
        int lat;
        int busy_cycles;
        issue(op, a, b, sh);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 1;
        busy_cycles = 1;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cycles++;
        end
        check({tag, "_lat"},   32'(lat),       32'(exp_lat));
        check({tag, "_bcyc"},  32'(busy_cycles), 32'(exp_lat));
        check({tag, "_done"},  32'(done),      32'd1);
        check({tag, "_res"},   ALUResult,      exp_res);
        check({tag, "_zero"},  32'(Zero),      32'(exp_zero));
        check({tag, "_inv"},   32'(InvalidOp), 32'(exp_inv));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(done),      32'd0);
        check({tag, "_idle"},  32'(busy),      32'd0);
        check({tag, "_hold"},  ALUResult,      exp_res);
    endtask

    initial begin
        int lat;
        int done_seen;
        n_pass       = 0;
        n_total      = 0;
        reset        = 1'b1;
        start        = 1'b0;
        ALUOperation = 4'b0000;
        A            = '0;
        B            = '0;
        shamt        = '0;

        #12;
        check("rst_busy", 32'(busy),      32'd0);
        check("rst_done", 32'(done),      32'd0);
        check("rst_res",  ALUResult,      32'd0);
        check("rst_zero", 32'(Zero),      32'd0);
        check("rst_inv",  32'(InvalidOp), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD wrap into sign bit
        run_op("add", 4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1);
        // SUB for the BEQ path
        run_op("sub_eq", 4'b0100, 32'd5, 32'd5, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 1);
        run_op("sub_ne", 4'b0100, 32'd5, 32'd6, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        // Iterative shifts, including the maximum amount
        run_op("sll31", 4'b1111, 32'h0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 32);
        run_op("srl4",  4'b1110, 32'h0, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0, 5);
        run_op("srl0",  4'b1110, 32'h0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0, 1);
        run_op("sll_z", 4'b1111, 32'h0, 32'h0000_0002, 5'd31, 32'h0000_0000, 1'b1, 1'b0, 32);
        run_op("nor",   4'b0010, 32'h0, 32'h0,         5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        run_op("or",    4'b0001, 32'h00FF_0000, 32'h0000_00F0, 5'd0, 32'h00FF_00F0, 1'b0, 1'b0, 1);

        // Start during SHIFT is ignored; SLL result must win.
        issue(4'b1111, 32'h0, 32'h0000_0003, 5'd10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        ALUOperation = 4'b0011;
        A            = 32'd1;
        B            = 32'd2;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        wait_done(4, lat);
        check("ign_lat",  32'(lat),       32'd11);
        check("ign_done", 32'(done),      32'd1);
        check("ign_res",  ALUResult,      32'h0000_0C00);
        @(posedge clk);
        #1;
        check("ign_idle", 32'(busy),      32'd0);
        check("ign_done2", 32'(done),     32'd0);

        // Reset in the middle of a shift aborts it.
        issue(4'b1111, 32'h0, 32'h0000_0001, 5'd20);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy),      32'd0);
        check("abort_done", 32'(done),      32'd0);
        check("abort_res",  ALUResult,      32'd0);
        check("abort_zero", 32'(Zero),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("abort_quiet", 32'(done_seen), 32'd0);

        // Invalid op code, then a valid op clears InvalidOp
        run_op("inv",  4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b1, 1'b1, 1);
        run_op("and",  4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0, 1);
        // Back-to-back issue immediately after done
        run_op("inv2", 4'b0111, 32'h1, 32'h1, 5'd0, 32'h0000_0000, 1'b1, 1'b1, 1);
        run_op("sll1", 4'b1111, 32'h0, 32'h4000_0001, 5'd1, 32'h8000_0002, 1'b0, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
